// File: rtl/clock_pkg.sv
// Shared constants and helpers for the century clock counters.
// Month/year limits, widths and wrap-safe increment functions.
package clock_pkg;

  localparam int MON_MIN  = 1;
  localparam int MON_MAX  = 12;
  localparam int YEAR_MAX = 99;
  localparam int MON_W    = 4;
  localparam int YEAR_W   = 7;

  typedef logic [MON_W-1:0]  mon_t;
  typedef logic [YEAR_W-1:0] year_t;

  // Out-of-range months (0, 13..15) fall back to 1.
  function automatic mon_t mon_inc(mon_t m);
    if (m >= mon_t'(MON_MAX) || m < mon_t'(MON_MIN))
      return mon_t'(MON_MIN);
    return m + mon_t'(1);
  endfunction

  // Years above 99 fall back to 0.
  function automatic year_t year_inc(year_t y);
    if (y >= year_t'(YEAR_MAX))
      return '0;
    return y + year_t'(1);
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Synchroniser plus falling-edge pulse for an active-low button.
// Ports: clk, rst_n, btn_n (async, active-low) -> fall (1-cycle pulse).
module btn_sync_edge #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic fall
);

  logic [N-1:0] sync_q;
  logic         last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      last_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[N-2:0], btn_n};
      last_q <= sync_q[N-1];
    end
  end

  assign fall = last_q & ~sync_q[N-1];

endmodule

// File: rtl/count_mon_y.sv
// Month/year counting stage: carry from day counter, set buttons.
// Ports: clk, rst_n, set_mon, set_y, pulse_mon -> cnt_mon, cnt_y, pulse_c.
module count_mon_y
  import clock_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_mon,
  input  logic              set_y,
  input  logic              pulse_mon,
  output logic [MON_W-1:0]  cnt_mon,
  output logic [YEAR_W-1:0] cnt_y,
  output logic              pulse_c
);

  logic  mon_fall;
  logic  y_fall;
  logic  pulse_mon_q;
  logic  carry_rise;
  logic  year_carry;
  mon_t  mon_d;
  year_t yr_d;
  logic  pc_d;

  btn_sync_edge #(.N(SYNC_STAGES)) u_mon (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (set_mon),
    .fall  (mon_fall)
  );

  btn_sync_edge #(.N(SYNC_STAGES)) u_y (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (set_y),
    .fall  (y_fall)
  );

  assign carry_rise = pulse_mon & ~pulse_mon_q;

  // A set press in the same cycle swallows the carry entirely.
  assign year_carry = carry_rise & ~mon_fall
                    & (cnt_mon == mon_t'(MON_MAX));

  always_comb begin
    mon_d = cnt_mon;
    yr_d  = cnt_y;
    pc_d  = 1'b0;
    if (mon_fall || carry_rise)
      mon_d = mon_inc(cnt_mon);
    if (y_fall) begin
      yr_d = year_inc(cnt_y);
    end else if (year_carry) begin
      yr_d = year_inc(cnt_y);
      pc_d = (cnt_y == year_t'(YEAR_MAX));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_mon_q <= 1'b0;
      cnt_mon     <= mon_t'(MON_MIN);
      cnt_y       <= '0;
      pulse_c     <= 1'b0;
    end else begin
      pulse_mon_q <= pulse_mon;
      cnt_mon     <= mon_d;
      cnt_y       <= yr_d;
      pulse_c     <= pc_d;
    end
  end

endmodule
